prog_divider: RTL
=================

PROG_DIVIDER -- requirements
Module: prog_divider

Interface
REQ-001 SHALL have parameter W, default 8, bit width of divide ratio n.
REQ-002 SHALL have parameter PULSE_DEFAULT, default 0, reset value of the internal mode register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; when low, state holds.
REQ-006 SHALL have port n  input  W  requested divide ratio; sampled only at period boundaries or when idle.
REQ-007 SHALL have port mode  input  1  0 = square output, 1 = single-cycle pulse output; sampled at period boundaries.
REQ-008 SHALL have port adv  input  1  DPLL phase-advance request; shortens next period by one cycle.
REQ-009 SHALL have port ret  input  1  DPLL phase-retard request; lengthens next period by one cycle.
REQ-010 SHALL have port out  output  1  divided clock, registered.
REQ-011 SHALL have port tick  output  1  registered one-cycle strobe marking the first cycle of each period.
REQ-012 SHALL have port n_active  output  W  ratio governing the current period.
REQ-013 SHALL have port adj_pending  output  1  high while an adv/ret request awaits application.

Function
REQ-014 SHALL run an internal counter cnt over 0..P-1, with period P = n_active + adj. adj is in {-1,0,+1}, latched at period start. All arithmetic SHALL be W+1 bits, so P ranges 2..2^W.
REQ-015 SHALL be idle whenever n_active < 2: cnt=0, out=0, tick=0, and n is resampled on every en cycle.
REQ-016 On an en cycle, idle, with n >= 2, the block SHALL start a period: n_active<=n, cnt<=0, tick<=1, mode latched, out per REQ-018/019.
REQ-017 On an en cycle with cnt==P-1, the block SHALL wrap: cnt<=0, n_active<=n, mode latched, pending adj applied and cleared, tick<=1. Otherwise cnt<=cnt+1, tick<=0.
REQ-018 Square mode: out SHALL be high for cycles cnt < (P+1)>>1 and low otherwise; odd P gives the extra high cycle.
REQ-019 Pulse mode: out SHALL equal tick.
REQ-020 en low SHALL freeze cnt, n_active, out and pending adj, and SHALL force tick=0.
REQ-021 Pending adj register: adv sets -1, ret sets +1. adv and ret in the same cycle SHALL cancel (no change). A request opposite to the pending value SHALL clear it. A request equal to the pending value SHALL saturate (no accumulation).
REQ-022 An adv/ret arriving in the wrap cycle SHALL apply to the following period, not the one starting.
REQ-023 adv SHALL NOT reduce P below 2: with n_active=2 the request is consumed and P stays 2.
REQ-024 A change of n mid-period SHALL NOT alter the current period; out SHALL remain glitch-free.
REQ-025 n dropping below 2 SHALL take effect at the next wrap; the block then goes idle.

Reset
REQ-026 reset SHALL force cnt=0, n_active=0, out=0, tick=0, adj=0, adj_pending=0, mode register=PULSE_DEFAULT. This takes priority over en, adv and ret.
REQ-027 reset asserted mid-period SHALL drive out=0 on the next edge. The first period after deassertion SHALL start per REQ-016.

Structure
REQ-028 A shared package prog_div_pkg SHALL hold the mode encoding constants (MODE_SQUARE=0, MODE_PULSE=1) and the adj encoding (ADJ_NONE, ADJ_ADV, ADJ_RET).
REQ-029 The pending-adjust logic (REQ-021..023) SHALL be one sub-module, prog_div_adj, with ports clk, reset, adv, ret, consume, and outputs adj and pending.
REQ-030 The implementation SHALL be 120-400 lines of RTL with no latches and no combinational output paths.

Verification
REQ-031 W=8, n=4, square, en=1, reset released: out pattern SHALL be 1100 repeating, with tick on each first 1.
REQ-032 n=5, square: out SHALL be high 3 cycles, low 2. Switching to mode=1 SHALL give the pattern 10000 from the next wrap.
REQ-033 n=4, with n changed to 6 at cnt=1: the current period SHALL complete at 4 cycles, and the next period SHALL be 6 (111000).
REQ-034 n=4: adv pulse SHALL give a next period of 3 (110). ret pulse SHALL give 5 (11100). adv+ret in the same cycle SHALL give 4. adv at n=2 SHALL keep the period at 2.
REQ-035 n=0 after reset: out=0 and tick=0 indefinitely. Setting n=4 SHALL start a period on the next edge. Asserting reset at cnt=2 SHALL give out=0 next edge, and all outputs SHALL read zero.
REQ-036 en low for 3 cycles mid-period: out and cnt SHALL hold, tick SHALL stay 0, and the period SHALL be extended by exactly 3 cycles.

Source files
------------

// File: rtl/prog_div_pkg.sv
// Shared encodings for the programmable divider: output mode and phase-adjust codes.
package prog_div_pkg;

    // Output mode, latched at the start of every period.
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Phase adjustment applied to a period: none, one cycle shorter, one cycle longer.
    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_ADV  = 2'd1,
        ADJ_RET  = 2'd2
    } adj_e;

    // Fold one cycle's adv/ret requests into a pending adjustment.
    // Both requests together cancel, an opposite request clears the pending value,
    // and a repeated request saturates rather than accumulating.
    function automatic adj_e next_adj(input adj_e base, input logic adv, input logic ret);
        adj_e r;
        r = base;
        if (adv && !ret) begin
            r = (base == ADJ_RET) ? ADJ_NONE : ADJ_ADV;
        end else if (ret && !adv) begin
            r = (base == ADJ_ADV) ? ADJ_NONE : ADJ_RET;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_div_adj.sv
// Pending phase-adjust register fed by the DPLL adv/ret requests.
// consume marks a period wrap: the old value is handed to the new period and
// any request arriving in that same cycle lands in the now-empty register.
module prog_div_adj
    import prog_div_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    input  logic       ret,
    input  logic       consume,
    output logic [1:0] adj,
    output logic       pending
);

    adj_e adj_q, adj_d;

    // Next pending value: clear on consume, then fold in this cycle's requests.
    always_comb begin
        // NOTE: assign every always_comb output before any branch so no latch can be inferred.
        adj_d = adj_q;
        adj_d = next_adj(consume ? ADJ_NONE : adj_q, adv, ret);
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            adj_q <= ADJ_NONE;
        end else begin
            adj_q <= adj_d;
        end
    end

    assign adj     = adj_q;
    assign pending = (adj_q != ADJ_NONE);

endmodule

// File: rtl/prog_divider.sv
// Programmable clock divider with square/pulse output and DPLL phase trim.
// A period is P = n_active + adj cycles; n, mode and the pending adjustment
// are only taken at period boundaries, so the output never glitches mid-period.
module prog_divider
    import prog_div_pkg::*;
#(
    parameter int   W             = 8,
    parameter logic PULSE_DEFAULT = 1'b0
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] n,
    input  logic         mode,
    input  logic         adv,
    input  logic         ret,
    output logic         out,
    output logic         tick,
    output logic [W-1:0] n_active,
    output logic         adj_pending
);

    localparam logic [W:0]   ONE   = (W+1)'(1);
    localparam logic [W-1:0] N_MIN = W'(2);

    logic [W:0]   cnt_q, cnt_d;
    logic [W-1:0] n_active_q, n_active_d;
    logic         mode_q, mode_d;
    adj_e         cur_adj_q, cur_adj_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic         consume;
    logic [1:0]   pend_raw;
    adj_e         pend_adj;
    logic         pend_valid;
    logic [W:0]   period_q, period_d, half_d;

    // Period length from a ratio and its adjustment, in W+1 bits (range 2..2^W).
    function automatic logic [W:0] period_of(input logic [W-1:0] na, input adj_e a);
        logic [W:0] p;
        p = {1'b0, na};
        case (a)
            ADJ_ADV: p = p - ONE;
            ADJ_RET: p = p + ONE;
            default: ;
        endcase
        return p;
    endfunction

    // Requests are ignored while the divider is frozen.
    prog_div_adj u_adj (
        .clk     (clk),
        .reset   (reset),
        .adv     (adv & en),
        .ret     (ret & en),
        .consume (consume),
        .adj     (pend_raw),
        .pending (pend_valid)
    );

    assign pend_adj = adj_e'(pend_raw);
    assign period_q = period_of(n_active_q, cur_adj_q);

    // Counter, ratio, mode and adjustment sequencing: idle start, wrap or advance.
    always_comb begin
        cnt_d      = cnt_q;
        n_active_d = n_active_q;
        mode_d     = mode_q;
        cur_adj_d  = cur_adj_q;
        tick_d     = 1'b0;
        consume    = 1'b0;
        if (en) begin
            if (n_active_q < N_MIN) begin
                // Idle: resample n every enabled cycle; start a period once it is usable.
                n_active_d = n;
                cnt_d      = '0;
                cur_adj_d  = ADJ_NONE;
                if (n >= N_MIN) begin
                    tick_d = 1'b1;
                    mode_d = mode;
                end
            end else if (cnt_q == period_q - ONE) begin
                // Wrap: take the new ratio and mode, hand over the pending adjustment.
                cnt_d      = '0;
                n_active_d = n;
                mode_d     = mode;
                consume    = 1'b1;
                cur_adj_d  = pend_adj;
                // A shortening request at ratio 2 is consumed without effect.
                if (n == N_MIN && pend_adj == ADJ_ADV) begin
                    cur_adj_d = ADJ_NONE;
                end
                if (n < N_MIN) begin
                    cur_adj_d = ADJ_NONE;
                end else begin
                    tick_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // Output waveform for the coming cycle, derived from the next counter state.
    always_comb begin
        period_d = period_of(n_active_d, cur_adj_d);
        half_d   = (period_d + ONE) >> 1;
        out_d    = out_q;
        if (en) begin
            if (n_active_d < N_MIN) begin
                out_d = 1'b0;
            end else if (mode_d == MODE_PULSE) begin
                out_d = tick_d;
            end else begin
                out_d = (cnt_d < half_d);
            end
        end else if (mode_q == MODE_PULSE) begin
            // In pulse mode out mirrors tick, which is forced low while frozen.
            out_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            n_active_q <= '0;
            mode_q     <= PULSE_DEFAULT;
            cur_adj_q  <= ADJ_NONE;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            n_active_q <= n_active_d;
            mode_q     <= mode_d;
            cur_adj_q  <= cur_adj_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
        end
    end

    assign out         = out_q;
    assign tick        = tick_q;
    assign n_active    = n_active_q;
    assign adj_pending = pend_valid;

endmodule
